// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
// Holds the requester count, the FSM state encoding and an index-to-one-hot helper.
package mux4_rr_arbiter_pkg;

  localparam int ARB_N = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [ARB_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// rr_pick4: combinational rotate-and-priority-encode.
// Returns the first requester after 'last', wrapping around and ending with 'last' itself.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       last,
  output logic             found,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // NOTE: every output of this block gets a default before the loop, so no latch can be inferred.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    // Scan from farthest to nearest so the nearest requester after 'last' is written last and wins.
    for (int i = ARB_N; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// Grants are registered, held while the owner requests, and capped at MAX_HOLD cycles.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] gnt,
  output logic             s1,
  output logic             s0,
  output logic             busy
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state, state_nxt;
  logic [ARB_N-1:0]  gnt_nxt;
  logic [1:0]        sel, sel_nxt;
  logic [1:0]        last, last_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

  logic       release_grant;
  logic [1:0] pick_last;
  logic       pick_found;
  logic [1:0] pick_idx;

  // While granted, the rotation starts after the current owner, which becomes 'last' on release.
  assign pick_last = (state == ARB_GRANT) ? sel : last;

  rr_pick4 u_pick (
    .req   (req),
    .last  (pick_last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign release_grant = !req[sel] || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST));

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_nxt    = ARB_GRANT;
          gnt_nxt      = idx_to_onehot(pick_idx);
          sel_nxt      = pick_idx;
          hold_cnt_nxt = '0;
        end
      end
      ARB_GRANT: begin
        if (!release_grant) begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end else begin
          last_nxt     = sel;
          hold_cnt_nxt = '0;
          if (pick_found) begin
            gnt_nxt = idx_to_onehot(pick_idx);
            sel_nxt = pick_idx;
          end else begin
            // Select lines keep the last owner so the mux output stays stable while idle.
            state_nxt = ARB_IDLE;
            gnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      sel      <= 2'd0;
      last     <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  assign s1   = sel[1];
  assign s0   = sel[0];
  assign busy = |gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter with MAX_HOLD=8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1, s0, busy;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariant monitor: one-hot-or-zero grant, and select lines match the grant while busy.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(gnt)) begin
      errors++;
      $display("FAIL onehot0: gnt=%b is not one-hot-or-zero", gnt);
    end
    checks++;
    if (busy && (gnt !== (4'b0001 << {s1, s0}))) begin
      errors++;
      $display("FAIL sel_match: gnt=%b s1s0=%b%b", gnt, s1, s0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) step();
    checks++;
    if ({gnt, s1, s0, busy} !== 7'b0000_00_0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b s1s0=%b%b busy=%b want 0000 00 0", gnt, s1, s0, busy);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0001 || {s1, s0} !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b s1s0=%b%b want 0001 00", gnt, s1, s0);
    end
  endtask

  task automatic test_single_hold_release();
    do_reset();
    req = 4'b0100;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (gnt !== 4'b0100 || {s1, s0} !== 2'b10) begin
        errors++;
        $display("FAIL single_hold edge %0d: gnt=%b s1s0=%b%b want 0100 10", e, gnt, s1, s0);
      end
    end
    req = 4'b0000;
    for (int e = 4; e <= 6; e++) begin
      step();
      checks++;
      if (gnt !== 4'b0000 || {s1, s0} !== 2'b10 || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_idle edge %0d: gnt=%b s1s0=%b%b busy=%b want 0000 10 0",
                 e, gnt, s1, s0, busy);
      end
    end
  endtask

  task automatic test_rotation_all();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int e = 1; e <= 40; e++) begin
      step();
      exp = 4'b0001 << (((e - 1) / 8) % 4);
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("FAIL rotation edge %0d: gnt=%b want %b", e, gnt, exp);
      end
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    req = 4'b0010;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (gnt !== 4'b0010 || {s1, s0} !== 2'b01) begin
        errors++;
        $display("FAIL sole_req edge %0d: gnt=%b s1s0=%b%b want 0010 01", e, gnt, s1, s0);
      end
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 4'b0001;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL drop_setup: gnt=%b want 0001", gnt);
    end
    req = 4'b1011;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL drop_hold: gnt=%b want 0001", gnt);
    end
    req = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0010 || {s1, s0} !== 2'b01) begin
      errors++;
      $display("FAIL drop_next: gnt=%b s1s0=%b%b want 0010 01", gnt, s1, s0);
    end
    req = 4'b1000;
    step();
    checks++;
    if (gnt !== 4'b1000 || {s1, s0} !== 2'b11) begin
      errors++;
      $display("FAIL drop_back_to_back: gnt=%b s1s0=%b%b want 1000 11", gnt, s1, s0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1000;
    step();
    step();
    checks++;
    if (gnt !== 4'b1000 || {s1, s0} !== 2'b11) begin
      errors++;
      $display("FAIL async_setup: gnt=%b s1s0=%b%b want 1000 11", gnt, s1, s0);
    end
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    checks++;
    if ({gnt, s1, s0, busy} !== 7'b0000_00_0) begin
      errors++;
      $display("FAIL async_clear: gnt=%b s1s0=%b%b busy=%b want 0000 00 0", gnt, s1, s0, busy);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL async_first_after: gnt=%b want 0001", gnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_single_hold_release();
    test_rotation_all();
    test_sole_requester();
    test_owner_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
